// File: rtl/dat_control_multiblock.sv
// DAT-line transfer controller: sequences single/multi-block transfers towards the DAT
// physical layer with an exact block counter, a timeout counter, abort and error reporting.
module dat_control_multiblock #(
  parameter int unsigned BLKCNT_W  = 16,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 newService,
  input  logic                 writeRead,
  input  logic                 multiblock,
  input  logic [BLKCNT_W-1:0]  blockCount,
  input  logic                 timeoutenable,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic                 abort,
  input  logic                 IDLE_in,
  input  logic                 fifo_ready,
  input  logic                 recibido,
  input  logic                 transferComplete,
  input  logic                 crc_error_in,
  output logic                 newService_fisica,
  output logic                 writeRead_fisica,
  output logic [TIMEOUT_W-1:0] timeout_fisica,
  output logic                 reset_fisica,
  output logic                 complete,
  output logic                 IDLE_out,
  output logic                 timeout_error,
  output logic                 crc_error,
  output logic [BLKCNT_W-1:0]  blocks_done
);

  typedef enum logic [2:0] {
    StReset,
    StIdle,
    StCheckFifo,
    StRequest,
    StWaitResp,
    StWaitIdle,
    StError
  } state_e;

  state_e               state_q, state_d;
  logic                 write_read_q, write_read_d;
  logic                 multiblock_q, multiblock_d;
  logic [BLKCNT_W-1:0]  block_count_q, block_count_d;
  logic                 tout_en_q, tout_en_d;
  // Holds the timeout value already masked by the enable; also drives timeout_fisica.
  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic [TIMEOUT_W-1:0] tout_cnt_q, tout_cnt_d;
  logic [BLKCNT_W-1:0]  blocks_done_q, blocks_done_d;
  logic                 timeout_error_q, timeout_error_d;
  logic                 crc_error_q, crc_error_d;
  logic                 complete_q, complete_d;
  logic                 new_service_fisica_q, new_service_fisica_d;
  logic                 reset_fisica_q, reset_fisica_d;
  logic                 idle_out_q, idle_out_d;

  logic [BLKCNT_W-1:0]  block_target;
  logic [BLKCNT_W-1:0]  blocks_done_inc;
  logic [TIMEOUT_W-1:0] tout_cnt_inc;
  logic                 timeout_hit;
  logic                 abort_active;

  // A multiblock request for zero blocks behaves like a single block.
  always_comb begin
    block_target = BLKCNT_W'(1);
    if (multiblock_q && (block_count_q != '0)) begin
      block_target = block_count_q;
    end
  end

  assign blocks_done_inc = (&blocks_done_q) ? blocks_done_q : blocks_done_q + BLKCNT_W'(1);
  assign tout_cnt_inc    = tout_cnt_q + TIMEOUT_W'(1);
  assign timeout_hit     = tout_en_q && (timeout_q != '0) && (tout_cnt_inc == timeout_q);
  assign abort_active    = abort &&
                           (state_q inside {StCheckFifo, StRequest, StWaitResp, StWaitIdle});

  always_comb begin
    state_d         = state_q;
    write_read_d    = write_read_q;
    multiblock_d    = multiblock_q;
    block_count_d   = block_count_q;
    tout_en_d       = tout_en_q;
    timeout_d       = timeout_q;
    tout_cnt_d      = tout_cnt_q;
    blocks_done_d   = blocks_done_q;
    timeout_error_d = timeout_error_q;
    crc_error_d     = crc_error_q;
    complete_d      = 1'b0;

    if (abort_active) begin
      state_d = StError;
    end else begin
      case (state_q)
        StReset: begin
          if (IDLE_in) begin
            state_d = StIdle;
          end
        end
        StIdle: begin
          if (newService) begin
            write_read_d    = writeRead;
            multiblock_d    = multiblock;
            block_count_d   = blockCount;
            tout_en_d       = timeoutenable;
            timeout_d       = timeoutenable ? timeout : '0;
            timeout_error_d = 1'b0;
            crc_error_d     = 1'b0;
            blocks_done_d   = '0;
            state_d         = StCheckFifo;
          end
        end
        StCheckFifo: begin
          if (fifo_ready) begin
            state_d = StRequest;
          end
        end
        StRequest: begin
          if (recibido) begin
            tout_cnt_d = '0;
            state_d    = StWaitResp;
          end
        end
        StWaitResp: begin
          if (tout_en_q) begin
            tout_cnt_d = tout_cnt_inc;
          end
          // A completion arriving in the timeout cycle still counts as a completion.
          if (transferComplete) begin
            if (crc_error_in) begin
              crc_error_d = 1'b1;
              state_d     = StError;
            end else begin
              blocks_done_d = blocks_done_inc;
              state_d       = StWaitIdle;
            end
          end else if (timeout_hit) begin
            timeout_error_d = 1'b1;
            state_d         = StError;
          end
        end
        StWaitIdle: begin
          if (IDLE_in) begin
            if (blocks_done_q == block_target) begin
              complete_d = 1'b1;
              state_d    = StIdle;
            end else begin
              state_d = StCheckFifo;
            end
          end
        end
        StError: begin
          state_d = StReset;
        end
        default: begin
          state_d = StReset;
        end
      endcase
    end

    // Outputs are registered copies of the next state so they line up with state_q.
    new_service_fisica_d = (state_d == StRequest);
    reset_fisica_d       = (state_d == StError);
    idle_out_d           = (state_d == StIdle);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q              <= StReset;
      write_read_q         <= 1'b0;
      multiblock_q         <= 1'b0;
      block_count_q        <= '0;
      tout_en_q            <= 1'b0;
      timeout_q            <= '0;
      tout_cnt_q           <= '0;
      blocks_done_q        <= '0;
      timeout_error_q      <= 1'b0;
      crc_error_q          <= 1'b0;
      complete_q           <= 1'b0;
      new_service_fisica_q <= 1'b0;
      reset_fisica_q       <= 1'b1;
      idle_out_q           <= 1'b0;
    end else begin
      state_q              <= state_d;
      write_read_q         <= write_read_d;
      multiblock_q         <= multiblock_d;
      block_count_q        <= block_count_d;
      tout_en_q            <= tout_en_d;
      timeout_q            <= timeout_d;
      tout_cnt_q           <= tout_cnt_d;
      blocks_done_q        <= blocks_done_d;
      timeout_error_q      <= timeout_error_d;
      crc_error_q          <= crc_error_d;
      complete_q           <= complete_d;
      new_service_fisica_q <= new_service_fisica_d;
      reset_fisica_q       <= reset_fisica_d;
      idle_out_q           <= idle_out_d;
    end
  end

  assign newService_fisica = new_service_fisica_q;
  assign writeRead_fisica  = write_read_q;
  assign timeout_fisica    = timeout_q;
  assign reset_fisica      = reset_fisica_q;
  assign complete          = complete_q;
  assign IDLE_out          = idle_out_q;
  assign timeout_error     = timeout_error_q;
  assign crc_error         = crc_error_q;
  assign blocks_done       = blocks_done_q;

endmodule

// File: tb/tb_dat_control_multiblock.sv
// Directed bench for dat_control_multiblock: a transfer-level reference model checked every
// cycle, plus literal expectations on episode counts, latencies and flags per scenario.
module tb_dat_control_multiblock;

  localparam int BW = 16;
  localparam int TW = 16;
  localparam int W_NSF  = 0;
  localparam int W_IDLE = 1;

  localparam int PH_RST  = 0;
  localparam int PH_IDL  = 1;
  localparam int PH_CHK  = 2;
  localparam int PH_REQ  = 3;
  localparam int PH_WAIT = 4;
  localparam int PH_WIDL = 5;
  localparam int PH_ERR  = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          newService, writeRead, multiblock, timeoutenable, abort;
  logic [BW-1:0] blockCount;
  logic [TW-1:0] timeout;
  logic          IDLE_in, fifo_ready, recibido, transferComplete, crc_error_in;
  logic          newService_fisica, writeRead_fisica, reset_fisica, complete, IDLE_out;
  logic          timeout_error, crc_error;
  logic [TW-1:0] timeout_fisica;
  logic [BW-1:0] blocks_done;

  dat_control_multiblock #(.BLKCNT_W(BW), .TIMEOUT_W(TW)) dut (
    .clock            (clock),
    .reset            (reset),
    .newService       (newService),
    .writeRead        (writeRead),
    .multiblock       (multiblock),
    .blockCount       (blockCount),
    .timeoutenable    (timeoutenable),
    .timeout          (timeout),
    .abort            (abort),
    .IDLE_in          (IDLE_in),
    .fifo_ready       (fifo_ready),
    .recibido         (recibido),
    .transferComplete (transferComplete),
    .crc_error_in     (crc_error_in),
    .newService_fisica(newService_fisica),
    .writeRead_fisica (writeRead_fisica),
    .timeout_fisica   (timeout_fisica),
    .reset_fisica     (reset_fisica),
    .complete         (complete),
    .IDLE_out         (IDLE_out),
    .timeout_error    (timeout_error),
    .crc_error        (crc_error),
    .blocks_done      (blocks_done)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // Reference model: the transfer as a phase walk, stepped once per rising edge.
  int          cyc = 0;
  bit          mdl_valid = 1'b0;
  int          m_ph;
  bit          m_multi, m_ten;
  logic [BW-1:0] m_bc;
  int          m_elapsed;
  logic        e_nsf, e_wr, e_rf, e_cmp, e_idle, e_terr, e_cerr;
  logic [TW-1:0] e_to;
  logic [BW-1:0] e_done;

  task automatic model_step();
    bit aborting;
    int need;
    if (reset) begin
      mdl_valid = 1'b1;
      m_ph = PH_RST; m_multi = 0; m_ten = 0; m_bc = '0; m_elapsed = 0;
      e_wr = 0; e_to = '0; e_cmp = 0; e_terr = 0; e_cerr = 0; e_done = '0;
      e_nsf = 0; e_rf = 1; e_idle = 0;
      return;
    end
    e_cmp = 0;
    aborting = abort && (m_ph inside {PH_CHK, PH_REQ, PH_WAIT, PH_WIDL});
    if (aborting) begin
      m_ph = PH_ERR;
    end else begin
      case (m_ph)
        PH_RST: if (IDLE_in) m_ph = PH_IDL;
        PH_IDL: if (newService) begin
          e_wr = writeRead; m_multi = multiblock; m_bc = blockCount; m_ten = timeoutenable;
          e_to = timeoutenable ? timeout : '0;
          e_terr = 0; e_cerr = 0; e_done = '0;
          m_ph = PH_CHK;
        end
        PH_CHK: if (fifo_ready) m_ph = PH_REQ;
        PH_REQ: if (recibido) begin m_elapsed = 0; m_ph = PH_WAIT; end
        PH_WAIT: begin
          if (m_ten) m_elapsed++;
          if (transferComplete) begin
            if (crc_error_in) begin
              e_cerr = 1; m_ph = PH_ERR;
            end else begin
              if (e_done != '1) e_done = e_done + 1'b1;
              m_ph = PH_WIDL;
            end
          end else if (e_to != 0 && m_elapsed == int'(e_to)) begin
            e_terr = 1; m_ph = PH_ERR;
          end
        end
        PH_WIDL: if (IDLE_in) begin
          need = (m_multi && m_bc != 0) ? int'(m_bc) : 1;
          if (int'(e_done) == need) begin
            e_cmp = 1; m_ph = PH_IDL;
          end else begin
            m_ph = PH_CHK;
          end
        end
        default: m_ph = PH_RST;
      endcase
    end
    e_nsf  = (m_ph == PH_REQ);
    e_rf   = (m_ph == PH_ERR);
    e_idle = (m_ph == PH_IDL);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      model_step();
    end
  end

  // Per-cycle compare plus episode/pulse bookkeeping for the literal checks.
  int eps = 0, cmps = 0, eps_at_cmp = 0;
  int nsf_fall_cyc = 0, terr_rise_cyc = 0, rf_run = 0, rf_last = 0;
  logic prev_nsf = 0, prev_terr = 0;

  initial begin
    forever begin
      @(negedge clock);
      if (mdl_valid) begin
        chk("newService_fisica", newService_fisica, e_nsf);
        chk("writeRead_fisica", writeRead_fisica, e_wr);
        chk("timeout_fisica", timeout_fisica, e_to);
        chk("reset_fisica", reset_fisica, e_rf);
        chk("complete", complete, e_cmp);
        chk("IDLE_out", IDLE_out, e_idle);
        chk("timeout_error", timeout_error, e_terr);
        chk("crc_error", crc_error, e_cerr);
        chk("blocks_done", blocks_done, e_done);
      end
      if (newService_fisica && !prev_nsf) eps++;
      if (!newService_fisica && prev_nsf) nsf_fall_cyc = cyc;
      if (timeout_error && !prev_terr) terr_rise_cyc = cyc;
      if (complete) begin cmps++; eps_at_cmp = eps; end
      if (reset_fisica) rf_run++;
      else if (rf_run != 0) begin rf_last = rf_run; rf_run = 0; end
      prev_nsf  = newService_fisica;
      prev_terr = timeout_error;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clr_stats();
    eps = 0; cmps = 0; eps_at_cmp = 0;
  endtask

  task automatic wait_sig(input int which, input logic val, input int limit);
    bit hit = 0;
    for (int i = 0; i < limit; i++) begin
      if ((which == W_NSF ? newService_fisica : IDLE_out) === val) begin
        hit = 1;
        break;
      end
      tick();
    end
    chk(which == W_NSF ? "wait_newService_fisica" : "wait_IDLE_out", 32'(hit), 1);
  endtask

  task automatic start_xfer(input bit wr, input bit mb, input logic [BW-1:0] bc,
                            input bit ten, input logic [TW-1:0] to);
    wait_sig(W_IDLE, 1'b1, 50);
    writeRead = wr; multiblock = mb; blockCount = bc; timeoutenable = ten; timeout = to;
    newService = 1;
    tick();
    // Scramble the configuration so that only latched values can be correct.
    newService = 0; writeRead = ~wr; multiblock = ~mb; blockCount = bc + 7;
    timeoutenable = ~ten; timeout = to + 3;
  endtask

  task automatic serve_block(input int rec_dly, input int tc_dly, input bit crc, input bit fin);
    repeat (2) tick();
    fifo_ready = 1;
    wait_sig(W_NSF, 1'b1, 20);
    fifo_ready = 0;
    repeat (rec_dly) tick();
    recibido = 1;
    tick();
    recibido = 0; IDLE_in = 0;
    if (fin) begin
      repeat (tc_dly) tick();
      transferComplete = 1; crc_error_in = crc;
      tick();
      transferComplete = 0; crc_error_in = 0;
    end
    repeat (2) tick();
    IDLE_in = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1; newService = 0; writeRead = 0; multiblock = 0; blockCount = '0;
    timeoutenable = 0; timeout = '0; abort = 0; IDLE_in = 0; fifo_ready = 0;
    recibido = 0; transferComplete = 0; crc_error_in = 0;
    repeat (3) tick();
    chk("rst_reset_fisica", reset_fisica, 1);
    chk("rst_IDLE_out", IDLE_out, 0);
    chk("rst_blocks_done", blocks_done, 0);
    reset = 0; IDLE_in = 1;
    wait_sig(W_IDLE, 1'b1, 10);
    chk("idle_reset_fisica_low", reset_fisica, 0);

    // Single-block write, timeout disabled
    clr_stats();
    start_xfer(1, 0, 16'd0, 0, 16'd500);
    serve_block(2, 10, 0, 1);
    wait_sig(W_IDLE, 1'b1, 20);
    tick();
    chk("s1_episodes", eps, 1);
    chk("s1_complete", cmps, 1);
    chk("s1_blocks_done", blocks_done, 1);
    chk("s1_timeout_fisica", timeout_fisica, 0);
    chk("s1_writeRead", writeRead_fisica, 1);

    // Multiblock read of 3; a stray newService mid-transfer is ignored
    clr_stats();
    start_xfer(0, 1, 16'd3, 0, 16'd0);
    serve_block(3, 4, 0, 1);
    serve_block(1, 2, 0, 1);
    newService = 1;
    tick();
    newService = 0;
    serve_block(2, 5, 0, 1);
    wait_sig(W_IDLE, 1'b1, 20);
    tick();
    chk("s2_episodes", eps, 3);
    chk("s2_complete", cmps, 1);
    chk("s2_eps_at_complete", eps_at_cmp, 3);
    chk("s2_blocks_done", blocks_done, 3);
    chk("s2_writeRead", writeRead_fisica, 0);

    // Multiblock with blockCount=0 behaves as one block
    clr_stats();
    start_xfer(1, 1, 16'd0, 0, 16'd0);
    serve_block(1, 3, 0, 1);
    wait_sig(W_IDLE, 1'b1, 20);
    tick();
    chk("s3_episodes", eps, 1);
    chk("s3_complete", cmps, 1);
    chk("s3_blocks_done", blocks_done, 1);

    // Timeout of 20 cycles with no completion
    clr_stats();
    start_xfer(0, 0, 16'd0, 1, 16'd20);
    chk("s4_timeout_fisica", timeout_fisica, 20);
    serve_block(2, 0, 0, 0);
    wait_sig(W_IDLE, 1'b1, 80);
    tick();
    chk("s4_latency", terr_rise_cyc - nsf_fall_cyc, 20);
    chk("s4_reset_pulse_width", rf_last, 1);
    chk("s4_no_complete", cmps, 0);
    chk("s4_timeout_error", timeout_error, 1);
    chk("s4_crc_error", crc_error, 0);

    // CRC failure on block 2 of 4, then a new start clears the flag
    clr_stats();
    start_xfer(0, 1, 16'd4, 0, 16'd0);
    chk("s5_terr_cleared", timeout_error, 0);
    serve_block(1, 3, 0, 1);
    serve_block(1, 3, 1, 1);
    wait_sig(W_IDLE, 1'b1, 40);
    tick();
    chk("s5_crc_error", crc_error, 1);
    chk("s5_blocks_done", blocks_done, 1);
    chk("s5_no_complete", cmps, 0);
    chk("s5_episodes", eps, 2);
    start_xfer(0, 0, 16'd0, 0, 16'd0);
    chk("s5_crc_cleared", crc_error, 0);
    chk("s5_blocks_cleared", blocks_done, 0);
    serve_block(1, 2, 0, 1);
    wait_sig(W_IDLE, 1'b1, 20);
    tick();
    chk("s5_next_complete", cmps, 1);

    // Abort while the request is held
    clr_stats();
    start_xfer(1, 0, 16'd0, 0, 16'd0);
    repeat (2) tick();
    fifo_ready = 1;
    wait_sig(W_NSF, 1'b1, 20);
    fifo_ready = 0; IDLE_in = 0; abort = 1;
    tick();
    abort = 0;
    chk("s6_nsf_dropped", newService_fisica, 0);
    chk("s6_reset_fisica", reset_fisica, 1);
    tick();
    chk("s6_reset_fisica_end", reset_fisica, 0);
    repeat (3) tick();
    chk("s6_held_in_reset", IDLE_out, 0);
    IDLE_in = 1;
    wait_sig(W_IDLE, 1'b1, 10);
    tick();
    chk("s6_timeout_error", timeout_error, 0);
    chk("s6_crc_error", crc_error, 0);
    chk("s6_no_complete", cmps, 0);

    // Synchronous reset in the middle of a transfer
    start_xfer(0, 0, 16'd0, 1, 16'd100);
    serve_block(1, 0, 0, 0);
    reset = 1;
    tick();
    chk("s7_reset_fisica", reset_fisica, 1);
    chk("s7_timeout_fisica", timeout_fisica, 0);
    reset = 0;
    wait_sig(W_IDLE, 1'b1, 10);
    tick();
    chk("s7_idle", IDLE_out, 1);

    repeat (3) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
